// File: rtl/slot_op_scheduler_pkg.sv
// slot_sched_pkg: shared op/FSM encodings, phase thresholds and op selection for slot_op_scheduler
package slot_sched_pkg;
  localparam logic [7:0] TH_SHR = 8'd128;
  localparam logic [7:0] TH_CLR = 8'd192;
  localparam int MOD_STEPS = 32;
  typedef enum logic [1:0] {OP_MOD5, OP_DIV2, OP_SHR2, OP_CLEAR} op_e;
  typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_e;
  function automatic op_e op_sel(input logic [7:0] cnt);
    return (cnt == 8'd0) ? OP_MOD5 : (cnt < TH_SHR) ? OP_DIV2 : (cnt < TH_CLR) ? OP_SHR2 : OP_CLEAR;
  endfunction
endpackage

// File: rtl/slot_op_scheduler_if.sv
// slot_op_scheduler_if: operand handshake, result read port and commit status of the scheduler
interface slot_op_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int SLOTS  = 4
) ();
  localparam int PTR_W = $clog2(SLOTS);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [PTR_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [SLOTS-1:0]  slot_valid;
  logic              commit_valid;
  logic [PTR_W-1:0]  commit_slot;
  logic              busy;
  modport master (
    output flush, in_valid, in_data, rd_addr,
    input  in_ready, rd_data, slot_valid, commit_valid, commit_slot, busy
  );
  modport slave (
    input  flush, in_valid, in_data, rd_addr,
    output in_ready, rd_data, slot_valid, commit_valid, commit_slot, busy
  );
endinterface

// File: rtl/slot_op_scheduler_mod5_serial.sv
// mod5_serial: bit-serial MSB-first modulo-5 reduction of one operand over MOD_STEPS cycles
module mod5_serial
  import slot_sched_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] operand_i,
  output logic [2:0]        rem_o,
  output logic              done_o
);
  logic [DATA_W-1:0] sh_q;
  logic [5:0]        step_q;
  logic [2:0]        r_q, r_d;
  logic              run_q;
  logic [3:0]        t;
  // r stays below 5, so one conditional subtract keeps it in range
  assign t      = {r_q, sh_q[DATA_W-1]};
  assign r_d    = (t >= 4'd5) ? 3'(t - 4'd5) : t[2:0];
  assign done_o = run_q && (step_q == 6'(MOD_STEPS - 1));
  assign rem_o  = r_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q   <= '0;
      step_q <= '0;
      r_q    <= '0;
      run_q  <= 1'b0;
    end else if (abort_i) begin
      step_q <= '0;
      run_q  <= 1'b0;
    end else if (start_i) begin
      sh_q   <= operand_i;
      step_q <= '0;
      r_q    <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      sh_q   <= sh_q << 1;
      r_q    <= r_d;
      step_q <= step_q + 6'd1;
      if (done_o) run_q <= 1'b0;
    end
  end
endmodule

// File: rtl/slot_op_scheduler.sv
// slot_op_scheduler: phase-selected operand ops written round-robin into a result array
module slot_op_scheduler
  import slot_sched_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SLOTS  = 4,
  parameter int CNT_W  = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  slot_op_scheduler_if.slave   bus
);
  localparam int PTR_W = $clog2(SLOTS);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  ptr_q, commit_slot_q;
  logic [SLOTS-1:0]  slot_valid_q;
  logic              commit_valid_q;
  logic [DATA_W-1:0] slots_q [SLOTS];
  logic              accept, mod_start, mod_done, wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [2:0]        mod_rem;
  op_e               op;
  assign bus.in_ready     = reset_n && !bus.flush && (state_q == IDLE);
  assign accept           = bus.in_valid && bus.in_ready;
  assign op               = op_sel(cnt_q);
  assign bus.busy         = (state_q != IDLE);
  assign bus.rd_data      = slots_q[bus.rd_addr];
  assign bus.slot_valid   = slot_valid_q;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_slot  = commit_slot_q;
  always_comb begin
    state_d   = state_q;
    mod_start = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    if (!bus.flush) begin
      unique case (state_q)
        IDLE: if (accept) begin
          mod_start = (op == OP_MOD5);
          wr_en     = (op != OP_MOD5);
          state_d   = (op == OP_MOD5) ? RUN : IDLE;
          wr_data   = (op == OP_DIV2) ? bus.in_data >> 1 : (op == OP_SHR2) ? bus.in_data >> 2 : '0;
        end
        RUN:    state_d = mod_done ? COMMIT : RUN;
        COMMIT: begin
          state_d = IDLE;
          wr_en   = 1'b1;
          wr_data = DATA_W'(mod_rem);
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
  // flush clears bookkeeping only; slot contents survive for the consumer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      ptr_q          <= '0;
      slot_valid_q   <= '0;
      commit_valid_q <= 1'b0;
      commit_slot_q  <= '0;
      for (int i = 0; i < SLOTS; i++) slots_q[i] <= '0;
    end else if (bus.flush) begin
      cnt_q          <= '0;
      ptr_q          <= '0;
      slot_valid_q   <= '0;
      commit_valid_q <= 1'b0;
      commit_slot_q  <= '0;
    end else begin
      cnt_q          <= cnt_q + CNT_W'(accept);
      commit_valid_q <= wr_en;
      if (wr_en) begin
        slots_q[ptr_q]      <= wr_data;
        commit_slot_q       <= ptr_q;
        slot_valid_q[ptr_q] <= 1'b1;
        ptr_q               <= ptr_q + PTR_W'(1);
      end
    end
  end
  mod5_serial #(.DATA_W(DATA_W)) u_mod5 (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (mod_start),
    .abort_i   (bus.flush),
    .operand_i (bus.in_data),
    .rem_o     (mod_rem),
    .done_o    (mod_done)
  );
endmodule

// File: tb/tb_slot_op_scheduler.sv
// tb_slot_op_scheduler: randomized operand stream checked against an arithmetic reference model
module tb_slot_op_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  slot_op_scheduler_if bus ();
  slot_op_scheduler dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  int n_pass = 0, n_chk = 0, n_fail = 0;
  int cnt, ptr, wait_n, guard;
  logic [3:0]  sv;
  logic [31:0] mem [4];
  logic [31:0] pend;
  logic        exp_cv;
  logic [1:0]  exp_cs;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    cnt = 0; ptr = 0; wait_n = 0; sv = '0; exp_cv = 1'b0; exp_cs = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
  endtask
  task automatic wr(input logic [31:0] x);
    mem[ptr] = x; exp_cv = 1'b1; exp_cs = 2'(ptr); sv[ptr] = 1'b1; ptr = (ptr + 1) % 4;
  endtask
  // one clock: drive, check combinational outputs, edge, advance model, check registered outputs
  task automatic cycle(input bit v, input logic [31:0] d, input bit fl, input logic [1:0] ra);
    bit rdy;
    bus.in_valid = v; bus.in_data = d; bus.flush = fl; bus.rd_addr = ra;
    #1;
    rdy = (wait_n == 0) && !fl;
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    chk("rd_data", bus.rd_data, mem[ra]);
    @(posedge clk); #1;
    exp_cv = 1'b0;
    if (fl) begin
      cnt = 0; ptr = 0; sv = '0; wait_n = 0;
    end else if (wait_n > 0) begin
      wait_n--;
      if (wait_n == 0) wr(pend % 5);
    end else if (v && rdy) begin
      if (cnt == 0) begin wait_n = 33; pend = d; end
      else wr(cnt < 128 ? d / 2 : cnt < 192 ? d >> 2 : 32'd0);
      cnt = (cnt + 1) % 256;
    end
    chk("commit_valid", 32'(bus.commit_valid), 32'(exp_cv));
    if (exp_cv) chk("commit_slot", 32'(bus.commit_slot), 32'(exp_cs));
    chk("slot_valid", 32'(bus.slot_valid), 32'(sv));
    chk("busy", 32'(bus.busy), 32'(wait_n > 0));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 1'b0, 2'($urandom));
  endtask
  task automatic run_to(input int target);
    guard = 0;
    while (cnt != target && guard < 2000) begin
      cycle($urandom_range(0, 3) != 0, $urandom, 1'b0, 2'($urandom));
      guard++;
    end
    chk("run_to_reached", 32'(cnt), 32'(target));
  endtask
  task automatic peek(input logic [1:0] ra, input logic [31:0] exp, input string tag);
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.rd_addr = ra;
    #1;
    chk(tag, bus.rd_data, exp);
    @(posedge clk); #1;
    exp_cv = 1'b0;
  endtask
  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.rd_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_slot_valid", 32'(bus.slot_valid), 32'd0);
    chk("rst_commit_valid", 32'(bus.commit_valid), 32'd0);
    chk("rst_commit_slot", 32'(bus.commit_slot), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 32'd17, 1'b0, 2'd0);
    idle(33);
    chk("mod5_17_commit", 32'(bus.commit_valid), 32'd1);
    chk("mod5_17_sv", 32'(bus.slot_valid), 32'b0001);
    peek(2'd0, 32'd2, "mod5_17_val");
    cycle(1'b1, 32'd100, 1'b0, 2'd1);
    cycle(1'b1, 32'd7, 1'b0, 2'd2);
    chk("div2_sv", 32'(bus.slot_valid), 32'b0111);
    peek(2'd1, 32'd50, "div2_100");
    peek(2'd2, 32'd3, "div2_7");
    run_to(128);
    cycle(1'b1, 32'h100, 1'b0, 2'd0);
    peek(2'd0, 32'h40, "shr2_100");
    run_to(192);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 2'd0);
    peek(2'd0, 32'd0, "clear_ff");
    run_to(0);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 2'd0);
    chk("wrap_mod5_busy", 32'(bus.busy), 32'd1);
    idle(33);
    chk("wrap_mod5_slot", 32'(bus.commit_slot), 32'd0);
    peek(2'd0, 32'd0, "wrap_mod5_val");
    cycle(1'b0, 32'd0, 1'b1, 2'd0);
    cycle(1'b1, 32'd12, 1'b0, 2'd0);
    idle(10);
    cycle(1'b1, 32'd5, 1'b1, 2'd0);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_sv", 32'(bus.slot_valid), 32'd0);
    chk("flush_cv", 32'(bus.commit_valid), 32'd0);
    cycle(1'b1, 32'd12, 1'b0, 2'd0);
    chk("flush_cnt_zero", 32'(bus.busy), 32'd1);
    idle(33);
    chk("flush_ptr_zero", 32'(bus.commit_slot), 32'd0);
    peek(2'd0, 32'd2, "mod5_12");
    cycle(1'b1, 32'd40, 1'b0, 2'd1);
    cycle(1'b1, 32'd60, 1'b0, 2'd2);
    cycle(1'b1, 32'h1234, 1'b0, 2'd3);
    chk("coll_new", bus.rd_data, 32'h91A);
    cycle(1'b0, 32'd0, 1'b1, 2'd0);
    cycle(1'b1, 32'd99, 1'b0, 2'd3);
    idle(5);
    bus.rd_addr = 2'd3;
    #2 reset_n = 1'b0;
    #1;
    chk("async_in_ready", 32'(bus.in_ready), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    chk("async_sv", 32'(bus.slot_valid), 32'd0);
    chk("async_cv", 32'(bus.commit_valid), 32'd0);
    chk("async_cs", 32'(bus.commit_slot), 32'd0);
    chk("async_rd", bus.rd_data, 32'd0);
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 32'd8, 1'b0, 2'd0);
    idle(33);
    peek(2'd0, 32'd3, "post_rst_mod5");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/slot_op_scheduler.md
Name: slot_op_scheduler

Overview:
- Accepts a stream of 32-bit operands over a valid/ready handshake.
- Chooses an arithmetic operation for each operand from an internal phase counter and assigns the result to a 4-entry result array in round-robin order.
- Sequences a multi-cycle modulo-5 unit and stalls the input while that unit is busy.
- Sits between the operand source and the downstream consumer of the result array.

Parameters:
- DATA_W, 32, operand/result width.
- SLOTS, 4, result array depth; must be a power of two ≥ 2.
- CNT_W, 8, phase counter width; thresholds below assume 8.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of counters, pointer, valids; aborts MOD5.
- in_valid  input  1  operand valid.
- in_ready  output  1  scheduler can accept an operand.
- in_data  input  DATA_W  operand.
- rd_addr  input  log2(SLOTS)  result read address.
- rd_data  output  DATA_W  combinational read of slot[rd_addr].
- slot_valid  output  SLOTS  per-slot written-since-flush flags.
- commit_valid  output  1  one-cycle pulse on each slot write.
- commit_slot  output  log2(SLOTS)  slot written this cycle.
- busy  output  1  MOD5 in progress.

Behaviour:
- Reset (async, reset_n=0):
  - State returns to IDLE.
  - phase cnt=0, slot ptr=0, slot_valid=0, commit_valid=0, commit_slot=0, busy=0.
  - in_ready=0 while reset_n is low.
  - Array contents are cleared to 0.
- Accept happens when in_valid && in_ready at a rising edge. On each accept, cnt increments by 1 and wraps 255→0.
- Op select uses cnt before the increment:
  - cnt==0 → MOD5 (in_data % 5).
  - 1..127 → DIV2 (unsigned in_data/2).
  - 128..191 → SHR2 (logical in_data>>2).
  - 192..255 → CLEAR (result 0).
- IDLE state:
  - in_ready=1.
  - DIV2/SHR2/CLEAR: slot[ptr] is written at the accept edge. commit_valid=1 and commit_slot=ptr hold for the following cycle. ptr increments (wrapping at SLOTS) and slot_valid[ptr] is set. Throughput is 1 operand/cycle; latency is 1.
  - MOD5: the operand is latched into the submodule and the FSM moves to RUN. busy=1 and in_ready=0 from the next cycle.
- RUN state:
  - The submodule performs 32 bit-serial steps, MSB first: r = (r<<1)|bit; if r ≥ 5 then r -= 5. r is 3 bits wide.
  - After step 32 the FSM moves to COMMIT.
- COMMIT state:
  - Lasts one cycle. slot[ptr] = r, commit pulse, ptr++, slot_valid set, back to IDLE.
  - in_ready=0 in COMMIT.
  - Accept-to-commit-pulse latency for MOD5 is 34 cycles. The next operand can be accepted in the cycle after COMMIT.
- flush:
  - Takes priority over every event in the same cycle.
  - Resets cnt, ptr, slot_valid, commit_valid, busy and the FSM to IDLE. An operand presented in the flush cycle is not accepted.
  - Array data is retained and only slot_valid clears.
  - A MOD5 in flight is discarded with no commit.
- Read/write collision: rd_data shows the old value in the write cycle and the new value after the edge.
- Overwrite: a slot is overwritten on ptr wrap with no backpressure; the consumer owns read timing.
- reset_n asserted mid-RUN aborts immediately with no commit.

Decomposition:
- Shared package slot_sched_pkg holds:
  - op enum {OP_MOD5, OP_DIV2, OP_SHR2, OP_CLEAR};
  - FSM enum {IDLE, RUN, COMMIT};
  - threshold constants TH_SHR=8'd128, TH_CLR=8'd192;
  - MOD_STEPS=32.
- One sub-module, mod5_serial: start, operand, 6-bit step counter, 3-bit remainder, done pulse, and an abort input driven by flush.

Test Plan:
- Release reset, send 17 (cnt=0) → in_ready drops for 33 cycles; commit pulse at cycle 34 with slot 0 = 2; busy deasserts; slot_valid=0001.
- Send 100 then 7 back-to-back (cnt=1,2) → consecutive commit pulses for slots 1 and 2 with values 50 and 3; in_ready stays high; slot_valid=0111.
- Advance cnt to 128 and send 0x100 → SHR2 slot (128 mod 4 = 0) = 0x40. At cnt=192, send 0xFFFFFFFF → slot written with 0.
- Send 256 operands from reset → operands at cnt=0 and at the wrap back to 0 both take the MOD5 path; ptr wraps; 0xFFFFFFFF at cnt=0 commits 0 (2^32−1 is divisible by 5).
- Start MOD5 on 12, assert flush at step 10 → no commit pulse; busy=0 the next cycle; cnt=0, ptr=0, slot_valid=0.
- Pull reset_n low mid-RUN asynchronously (between edges) → all outputs reach reset values without waiting for a clock edge. Then reading slot 3 with rd_addr=3 during its write cycle returns the old value.
